// File: rtl/snake_score_counter.sv
// Running score and session high score in packed BCD, updated by a digit-serial
// add that saturates at all nines and commits the whole result in one edge.
module snake_score_counter #(
    parameter int SCORE_WIDTH = 16
) (
    input  logic                   i_Clk,
    input  logic                   i_Reset,
    input  logic                   i_GameReset,
    input  logic                   i_Add,
    input  logic [3:0]             i_Points,
    output logic [SCORE_WIDTH-1:0] o_Score,
    output logic [SCORE_WIDTH-1:0] o_HighScore,
    output logic                   o_Busy,
    output logic                   o_Done,
    output logic                   o_Drop,
    output logic                   o_Overflow
);

    localparam int NUM_DIGITS = SCORE_WIDTH / 4;
    localparam int DIGIT_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [SCORE_WIDTH-1:0] ALL_NINES = {NUM_DIGITS{4'h9}};
    localparam logic [DIGIT_W-1:0]     LAST_DIGIT = DIGIT_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADD,
        ST_COMMIT
    } state_t;

    state_t                 state_q, state_d;
    logic [SCORE_WIDTH-1:0] work_q, work_d;
    logic [3:0]             addend_q, addend_d;
    logic [DIGIT_W-1:0]     digit_q, digit_d;
    logic                   carry_q, carry_d;
    logic [SCORE_WIDTH-1:0] score_q, score_d;
    logic [SCORE_WIDTH-1:0] high_q, high_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   drop_q, drop_d;
    logic                   ovf_q, ovf_d;
    logic                   pend_valid_q, pend_valid_d;
    logic [3:0]             pend_pts_q, pend_pts_d;

    logic [3:0]             req_pts;
    logic [3:0]             cur_digit;
    logic [4:0]             digit_sum;
    logic [3:0]             new_digit;
    logic                   new_carry;
    logic [SCORE_WIDTH-1:0] commit_val;

    assign req_pts    = (i_Points > 4'd9) ? 4'd9 : i_Points;
    assign commit_val = carry_q ? ALL_NINES : work_q;

    // Digit-serial adder: digit 0 takes the addend, later digits take the carry.
    always_comb begin
        cur_digit = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_q == DIGIT_W'(i)) begin
                cur_digit = work_q[i*4 +: 4];
            end
        end
        if (digit_q == '0) begin
            digit_sum = {1'b0, cur_digit} + {1'b0, addend_q};
        end else begin
            digit_sum = {1'b0, cur_digit} + {4'd0, carry_q};
        end
        if (digit_sum > 5'd9) begin
            new_digit = digit_sum[3:0] - 4'd10;
            new_carry = 1'b1;
        end else begin
            new_digit = digit_sum[3:0];
            new_carry = 1'b0;
        end
    end

    always_comb begin
        state_d      = state_q;
        work_d       = work_q;
        addend_d     = addend_q;
        digit_d      = digit_q;
        carry_d      = carry_q;
        score_d      = score_q;
        high_d       = high_q;
        ovf_d        = ovf_q;
        pend_valid_d = pend_valid_q;
        pend_pts_d   = pend_pts_q;
        done_d       = 1'b0;
        drop_d       = 1'b0;

        if (i_Reset || i_GameReset) begin
            state_d      = ST_IDLE;
            work_d       = '0;
            addend_d     = 4'd0;
            digit_d      = '0;
            carry_d      = 1'b0;
            score_d      = '0;
            ovf_d        = 1'b0;
            pend_valid_d = 1'b0;
            pend_pts_d   = 4'd0;
            if (i_Reset) begin
                high_d = '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_Add) begin
                        work_d   = score_q;
                        addend_d = req_pts;
                        digit_d  = '0;
                        carry_d  = 1'b0;
                        state_d  = ST_ADD;
                    end
                end

                ST_ADD: begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        if (digit_q == DIGIT_W'(i)) begin
                            work_d[i*4 +: 4] = new_digit;
                        end
                    end
                    carry_d = new_carry;
                    if (digit_q == LAST_DIGIT) begin
                        state_d = ST_COMMIT;
                    end else begin
                        digit_d = digit_q + DIGIT_W'(1);
                    end
                    if (i_Add) begin
                        if (!pend_valid_q) begin
                            pend_valid_d = 1'b1;
                            pend_pts_d   = req_pts;
                        end else begin
                            drop_d = 1'b1;
                        end
                    end
                end

                ST_COMMIT: begin
                    score_d = commit_val;
                    done_d  = 1'b1;
                    if (carry_q) begin
                        ovf_d = 1'b1;
                    end
                    if (commit_val > high_q) begin
                        high_d = commit_val;
                    end
                    // A queued request chains straight on from the value just committed.
                    if (pend_valid_q) begin
                        work_d       = commit_val;
                        addend_d     = pend_pts_q;
                        digit_d      = '0;
                        carry_d      = 1'b0;
                        state_d      = ST_ADD;
                        pend_valid_d = i_Add;
                        if (i_Add) begin
                            pend_pts_d = req_pts;
                        end
                    end else if (i_Add) begin
                        work_d   = commit_val;
                        addend_d = req_pts;
                        digit_d  = '0;
                        carry_d  = 1'b0;
                        state_d  = ST_ADD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_Clk) begin
        state_q      <= state_d;
        work_q       <= work_d;
        addend_q     <= addend_d;
        digit_q      <= digit_d;
        carry_q      <= carry_d;
        score_q      <= score_d;
        high_q       <= high_d;
        busy_q       <= busy_d;
        done_q       <= done_d;
        drop_q       <= drop_d;
        ovf_q        <= ovf_d;
        pend_valid_q <= pend_valid_d;
        pend_pts_q   <= pend_pts_d;
    end

    assign o_Score     = score_q;
    assign o_HighScore = high_q;
    assign o_Busy      = busy_q;
    assign o_Done      = done_q;
    assign o_Drop      = drop_q;
    assign o_Overflow  = ovf_q;

endmodule
